csr_cnt64_pipe: RTL and testbench
=================================

CSR_CNT64_PIPE -- requirements
Module: csr_cnt64_pipe

Interface
REQ-001 Parameter: INIT_VALUE, default 0, 64-bit reset value; bits [31:0] go to the low half, bits [63:32] to the high half.
REQ-002 Parameter: LO_ADDR, default 0, 12-bit CSR address of the low half; bits [9:8] give the lowest privilege allowed to write it.
REQ-003 Parameter: HI_ADDR, default 0, 12-bit CSR address of the high half; bits [9:8] give the lowest privilege allowed to write it.
REQ-004 Parameter: INC_W, default 2, width of the per-cycle increment (retire count).
REQ-005 clk_in  input  1  sole clock; all state updates on its rising edge.
REQ-006 reset_in  input  1  asynchronous, active-low reset.
REQ-007 mode  input  2  current privilege level.
REQ-008 inhibit  input  1  1 = counting suspended (mcountinhibit bit).
REQ-009 inc  input  INC_W  events this cycle, zero-extended before add.
REQ-010 csr_wr_lo  input  1  write strobe for the low half.
REQ-011 csr_wr_hi  input  1  write strobe for the high half.
REQ-012 newCSR  input  RSZ  write data, shared by both strobes.
REQ-013 csr_lo  output  RSZ  low 32 bits of the count, registered.
REQ-014 csr_hi  output  RSZ  high 32 bits of the count, registered.
REQ-015 ovf  output  1  sticky 64-bit overflow flag, registered.

Function
REQ-016 A low write is accepted only when csr_wr_lo=1 and mode >= LO_ADDR[9:8]; a high write only when csr_wr_hi=1 and mode >= HI_ADDR[9:8]; a refused write has no effect.
REQ-017 Low half, in priority order: accepted low write -> csr_lo <= newCSR; else inhibit=0 -> csr_lo <= (csr_lo + inc) mod 2^32; else hold.
REQ-018 Internal flop carry_pend <= 1 only when the REQ-017 increment path is taken and csr_lo + inc >= 2^32; otherwise carry_pend <= 0.
REQ-019 High half, in priority order: accepted high write -> csr_hi <= newCSR and the current carry_pend is discarded; else carry_pend=1 -> csr_hi <= (csr_hi + 1) mod 2^32; else hold.
REQ-020 The high half therefore reflects a low-half wrap exactly one cycle after csr_lo wraps (1-cycle carry pipeline); software reads hi/lo/hi to get a coherent value.
REQ-021 ovf <= 1 in the cycle csr_hi wraps from 0xFFFF_FFFF to 0 through the carry path; an accepted high write clears ovf to 0; otherwise ovf holds.
REQ-022 inhibit gates inc only; a carry already pending still propagates to csr_hi while inhibit=1.
REQ-023 Simultaneous accepted low and high writes take effect together; carry_pend becomes 0.
REQ-024 inc=0 with inhibit=0 holds csr_lo and generates no carry.
REQ-025 With INC_W <= 31, at most one carry is produced per cycle; this is the only supported range.

Reset
REQ-026 While reset_in=0, asynchronously: csr_lo = INIT_VALUE[31:0], csr_hi = INIT_VALUE[63:32], carry_pend = 0, ovf = 0.
REQ-027 A pending carry at reset assertion is lost; counting restarts from INIT_VALUE on the first rising edge after reset_in returns to 1.

Structure
REQ-028 RSZ comes from cpu_params_pkg; no new package types are required; INC_W is local to the block.
REQ-029 The high half plus ovf is one natural sub-module, csr_hi_cnt (inputs carry, write, data; outputs count and ovf); the low half and carry flop stay in the top.

Verification
REQ-030 Reset with INIT_VALUE=0x0000_0001_FFFF_FFFE, then inc=1 for 2 cycles -> csr_lo=0 after cycle 2, csr_hi=2 after cycle 3.
REQ-031 csr_lo=0xFFFF_FFFF, inc=3 -> csr_lo=2, and csr_hi increments by one on the following edge.
REQ-032 csr_lo=0xFFFF_FFFF, inc=1, with an accepted csr_wr_lo of newCSR=5 in the same cycle -> csr_lo=5 and csr_hi unchanged.
REQ-033 Carry pending with an accepted csr_wr_hi of 0x10 -> csr_hi=0x10, not 0x11, and ovf=0.
REQ-034 csr_hi=0xFFFF_FFFF, low wrap -> csr_hi=0 and ovf=1; inhibit=1 with inc=3 -> both halves hold; mode=0 with LO_ADDR=0xB00 and csr_wr_lo=1 -> write refused and counting continues.
REQ-035 reset_in driven low mid-count between clock edges -> outputs equal the INIT_VALUE halves immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/cpu_params_pkg.sv
// Shared CPU-wide parameters.
// Register width used by CSR datapaths.
package cpu_params_pkg;
  localparam int RSZ = 32;
endpackage

// File: rtl/csr_hi_cnt.sv
// High half of a 64-bit CSR counter.
// Increments on an incoming carry and holds a sticky overflow flag.
module csr_hi_cnt
  import cpu_params_pkg::*;
#(
  parameter logic [RSZ-1:0] INIT_HI = '0
) (
  input  logic           clk_i,
  input  logic           rst_ni,
  input  logic           carry_i,
  input  logic           wr_i,
  input  logic [RSZ-1:0] data_i,
  output logic [RSZ-1:0] cnt_o,
  output logic           ovf_o
);

  logic [RSZ-1:0] cnt_q, cnt_d;
  logic           ovf_q, ovf_d;

  // A write wins over a pending carry; a carry out of all-ones sets ovf.
  always_comb begin
    cnt_d = cnt_q;
    ovf_d = ovf_q;
    if (wr_i) begin
      cnt_d = data_i;
      ovf_d = 1'b0;
    end else if (carry_i) begin
      cnt_d = cnt_q + RSZ'(1);
      if (&cnt_q) ovf_d = 1'b1;
    end
  end

  // Count and overflow registers.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q <= INIT_HI;
      ovf_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      ovf_q <= ovf_d;
    end
  end

  assign cnt_o = cnt_q;
  assign ovf_o = ovf_q;

endmodule

// File: rtl/csr_cnt64_pipe.sv
// 64-bit event counter CSR pair with a 1-cycle carry pipeline.
// Low half and carry flop live here; the high half is csr_hi_cnt.
module csr_cnt64_pipe
  import cpu_params_pkg::*;
#(
  parameter logic [63:0] INIT_VALUE = 64'd0,
  parameter logic [11:0] LO_ADDR    = 12'd0,
  parameter logic [11:0] HI_ADDR    = 12'd0,
  parameter int          INC_W      = 2
) (
  input  logic             clk_in,
  input  logic             reset_in,
  input  logic [1:0]       mode,
  input  logic             inhibit,
  input  logic [INC_W-1:0] inc,
  input  logic             csr_wr_lo,
  input  logic             csr_wr_hi,
  input  logic [RSZ-1:0]   newCSR,
  output logic [RSZ-1:0]   csr_lo,
  output logic [RSZ-1:0]   csr_hi,
  output logic             ovf
);

  localparam logic [1:0] LO_PRIV = LO_ADDR[9:8];
  localparam logic [1:0] HI_PRIV = HI_ADDR[9:8];
  localparam logic [RSZ-1:0] INIT_LO = INIT_VALUE[31:0];
  localparam logic [RSZ-1:0] INIT_HI = INIT_VALUE[63:32];

  logic           lo_wr, hi_wr;
  logic [RSZ:0]   sum;
  logic [RSZ-1:0] lo_q, lo_d;
  logic           carry_q, carry_d;

  assign lo_wr = csr_wr_lo && (mode >= LO_PRIV);
  assign hi_wr = csr_wr_hi && (mode >= HI_PRIV);
  assign sum   = {1'b0, lo_q} + (RSZ+1)'(inc);

  // Low half: write, else increment, else hold.
  always_comb begin
    lo_d    = lo_q;
    carry_d = 1'b0;
    if (lo_wr) begin
      lo_d = newCSR;
    end else if (!inhibit) begin
      lo_d    = sum[RSZ-1:0];
      carry_d = sum[RSZ];
    end
  end

  // Low count and pipelined carry.
  always_ff @(posedge clk_in or negedge reset_in) begin
    if (!reset_in) begin
      lo_q    <= INIT_LO;
      carry_q <= 1'b0;
    end else begin
      lo_q    <= lo_d;
      carry_q <= carry_d;
    end
  end

  csr_hi_cnt #(
    .INIT_HI (INIT_HI)
  ) u_hi (
    .clk_i   (clk_in),
    .rst_ni  (reset_in),
    .carry_i (carry_q),
    .wr_i    (hi_wr),
    .data_i  (newCSR),
    .cnt_o   (csr_hi),
    .ovf_o   (ovf)
  );

  assign csr_lo = lo_q;

endmodule

// File: tb/tb_csr_cnt64_pipe.sv
// Randomized and directed bench for csr_cnt64_pipe.
// Reference model tracks halves and carry with plain arithmetic.
module tb_csr_cnt64_pipe;

  localparam logic [63:0] INIT = 64'h0000_0001_FFFF_FFFE;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [1:0]  mode = 2'd3;
  logic        inh = 1'b1;
  logic [1:0]  inc = 2'd0;
  logic        wlo = 1'b0;
  logic        whi = 1'b0;
  logic [31:0] data = 32'd0;
  logic [31:0] lo, hi;
  logic        ovf;

  int n_chk = 0;
  int n_err = 0;

  longint unsigned m_lo, m_hi;
  bit m_pend, m_ovf;

  csr_cnt64_pipe #(
    .INIT_VALUE (INIT),
    .LO_ADDR    (12'hB00),
    .HI_ADDR    (12'hB80),
    .INC_W      (2)
  ) dut (
    .clk_in    (clk),
    .reset_in  (rst_n),
    .mode      (mode),
    .inhibit   (inh),
    .inc       (inc),
    .csr_wr_lo (wlo),
    .csr_wr_hi (whi),
    .newCSR    (data),
    .csr_lo    (lo),
    .csr_hi    (hi),
    .ovf       (ovf)
  );

  always #5 clk = ~clk;

  task automatic check(string tag, logic [63:0] got, logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", tag, got, exp);
    end
  endtask

  task automatic m_reset();
    m_lo   = INIT % 64'h1_0000_0000;
    m_hi   = INIT / 64'h1_0000_0000;
    m_pend = 0;
    m_ovf  = 0;
  endtask

  task automatic m_step();
    longint unsigned s, nlo, nhi;
    bit acc_lo, acc_hi, npend, novf;
    acc_lo = wlo && (mode == 2'd3);
    acc_hi = whi && (mode == 2'd3);
    s = m_lo + longint'(inc);
    nlo = m_lo;
    npend = 0;
    if (acc_lo) nlo = data;
    else if (!inh) begin
      nlo = s % 64'h1_0000_0000;
      npend = (s >= 64'h1_0000_0000);
    end
    nhi = m_hi;
    novf = m_ovf;
    if (acc_hi) begin
      nhi = data;
      novf = 0;
    end else if (m_pend) begin
      nhi = (m_hi + 1) % 64'h1_0000_0000;
      if (nhi == 0) novf = 1;
    end
    m_lo = nlo;
    m_hi = nhi;
    m_pend = npend;
    m_ovf = novf;
  endtask

  task automatic cmp_model(string tag);
    check({tag, ".lo"}, 64'(lo), m_lo);
    check({tag, ".hi"}, 64'(hi), m_hi);
    check({tag, ".ovf"}, 64'(ovf), 64'(m_ovf));
  endtask

  task automatic tick(string tag);
    @(posedge clk);
    #1;
    m_step();
    cmp_model(tag);
  endtask

  task automatic drive(bit l, bit h, logic [31:0] d,
                       logic [1:0] i, bit in_h);
    wlo = l;
    whi = h;
    data = d;
    inc = i;
    inh = in_h;
  endtask

  initial begin
    m_reset();
    #12;
    check("rst.lo", 64'(lo), 64'hFFFF_FFFE);
    check("rst.hi", 64'(hi), 64'h1);
    check("rst.ovf", 64'(ovf), 64'h0);
    @(negedge clk);
    rst_n = 1'b1;

    drive(0, 0, 0, 1, 0);
    tick("w1");
    tick("w2");
    check("wrap.lo", 64'(lo), 64'h0);
    check("wrap.hi_early", 64'(hi), 64'h1);
    drive(0, 0, 0, 0, 0);
    tick("w3");
    check("wrap.hi", 64'(hi), 64'h2);

    drive(1, 0, 32'hFFFF_FFFF, 0, 0);
    tick("i3a");
    drive(0, 0, 0, 3, 0);
    tick("i3b");
    check("inc3.lo", 64'(lo), 64'h2);
    check("inc3.hi_early", 64'(hi), 64'h2);
    drive(0, 0, 0, 0, 0);
    tick("i3c");
    check("inc3.hi", 64'(hi), 64'h3);

    drive(1, 0, 32'hFFFF_FFFF, 0, 0);
    tick("wl_a");
    drive(1, 0, 32'd5, 1, 0);
    tick("wl_b");
    check("wrlo.lo", 64'(lo), 64'h5);
    drive(0, 0, 0, 0, 0);
    tick("wl_c");
    check("wrlo.hi", 64'(hi), 64'h3);

    drive(1, 0, 32'hFFFF_FFFF, 0, 0);
    tick("wh_a");
    drive(0, 0, 0, 1, 0);
    tick("wh_b");
    drive(0, 1, 32'h10, 0, 0);
    tick("wh_c");
    check("wrhi.hi", 64'(hi), 64'h10);
    check("wrhi.ovf", 64'(ovf), 64'h0);
    drive(0, 0, 0, 0, 0);
    tick("wh_d");
    check("wrhi.hold", 64'(hi), 64'h10);

    drive(1, 1, 32'hFFFF_FFFF, 0, 0);
    tick("ov_a");
    drive(0, 0, 0, 1, 0);
    tick("ov_b");
    drive(0, 0, 0, 0, 0);
    tick("ov_c");
    check("ovf.hi", 64'(hi), 64'h0);
    check("ovf.flag", 64'(ovf), 64'h1);

    drive(0, 0, 0, 3, 1);
    tick("inh_a");
    tick("inh_b");
    check("inh.lo", 64'(lo), 64'h0);
    check("inh.hi", 64'(hi), 64'h0);

    drive(1, 0, 32'hFFFF_FFFF, 0, 0);
    tick("pc_a");
    drive(0, 0, 0, 1, 0);
    tick("pc_b");
    drive(0, 0, 0, 3, 1);
    tick("pc_c");
    check("inhcarry.hi", 64'(hi), 64'h1);
    check("inhcarry.lo", 64'(lo), 64'h0);
    check("inhcarry.ovf", 64'(ovf), 64'h1);

    mode = 2'd0;
    drive(1, 0, 32'd77, 1, 0);
    tick("priv_a");
    check("priv.lo", 64'(lo), 64'h1);
    mode = 2'd3;

    for (int k = 0; k < 400; k++) begin
      mode = 2'($urandom_range(0, 3));
      inh  = ($urandom_range(0, 7) == 0);
      inc  = 2'($urandom);
      wlo  = ($urandom_range(0, 15) == 0);
      whi  = ($urandom_range(0, 15) == 0);
      case ($urandom_range(0, 3))
        0: data = 32'hFFFF_FFFF - 32'($urandom_range(0, 4));
        1: data = 32'($urandom_range(0, 4));
        default: data = $urandom;
      endcase
      tick("rnd");
    end

    drive(0, 0, 0, 3, 0);
    tick("pre_rst");
    #2;
    rst_n = 1'b0;
    #1;
    m_reset();
    check("arst.lo", 64'(lo), 64'hFFFF_FFFE);
    check("arst.hi", 64'(hi), 64'h1);
    check("arst.ovf", 64'(ovf), 64'h0);
    @(negedge clk);
    rst_n = 1'b1;
    drive(0, 0, 0, 1, 0);
    tick("post_rst");
    check("post.lo", 64'(lo), 64'hFFFF_FFFF);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
